// File: rtl/peripheral_memory_arbiter.sv
// Round-robin arbiter sharing one single-port 256x32 memory between the register path (A) and DMA (B).
// Define MEM_ARB_LOCK_EN to enable bounded burst locking (lock_a/lock_b, lock_owner).
module peripheral_memory_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8,
  parameter int MAX_LOCK  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic                 we_a,
  input  logic                 we_b,
  input  logic [ADDRWIDTH-1:0] addr_a,
  input  logic [ADDRWIDTH-1:0] addr_b,
  input  logic [DATAWIDTH-1:0] wdata_a,
  input  logic [DATAWIDTH-1:0] wdata_b,
  input  logic                 lock_a,
  input  logic                 lock_b,
  output logic                 gnt_a,
  output logic                 gnt_b,
  output logic                 rvalid_a,
  output logic                 rvalid_b,
  output logic [DATAWIDTH-1:0] rdata_a,
  output logic [DATAWIDTH-1:0] rdata_b,
  output logic [1:0]           lock_owner,
  output logic                 mem_write_en,
  output logic [ADDRWIDTH-1:0] mem_address,
  output logic [DATAWIDTH-1:0] mem_data_in,
  input  logic [DATAWIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t               state;
  logic                 rr;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0] wdata_q;

`ifdef MEM_ARB_LOCK_EN
  logic [7:0] lock_cnt;
  logic [7:0] cnt_inc;
  assign cnt_inc = lock_cnt + 8'd1;
`else
  logic unused_lock;
  assign unused_lock = ^{lock_a, lock_b, 8'(MAX_LOCK)};
  assign lock_owner  = 2'b00;
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (req_a && req_b) begin
            gnt_a = ~rr;
            gnt_b = rr;
          end else begin
            gnt_a = req_a;
            gnt_b = req_b;
          end
        end
        LOCK_A:  gnt_a = req_a;
        LOCK_B:  gnt_b = req_b;
        default: ;
      endcase
    end
  end

  // Address and data buses hold their last granted value between accesses.
  assign mem_write_en = (gnt_a & we_a) | (gnt_b & we_b);
  assign mem_address  = gnt_a ? addr_a  : (gnt_b ? addr_b  : addr_q);
  assign mem_data_in  = gnt_a ? wdata_a : (gnt_b ? wdata_b : wdata_q);
  assign rdata_a      = mem_data_out;
  assign rdata_b      = mem_data_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr       <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
      lock_cnt   <= 8'd0;
      lock_owner <= 2'b00;
`endif
    end else begin
      rvalid_a <= gnt_a & ~we_a;
      rvalid_b <= gnt_b & ~we_b;
      if (gnt_a || gnt_b) begin
        addr_q  <= mem_address;
        wdata_q <= mem_data_in;
      end
      case (state)
        IDLE: begin
          if (gnt_a || gnt_b) begin
            rr <= gnt_a;
`ifdef MEM_ARB_LOCK_EN
            if (gnt_a && lock_a) begin
              state      <= LOCK_A;
              lock_cnt   <= 8'd1;
              lock_owner <= 2'b01;
            end else if (gnt_b && lock_b) begin
              state      <= LOCK_B;
              lock_cnt   <= 8'd1;
              lock_owner <= 2'b10;
            end
`endif
          end
        end
`ifdef MEM_ARB_LOCK_EN
        LOCK_A: begin
          if (!req_a || !lock_a || cnt_inc == 8'(MAX_LOCK)) begin
            state      <= IDLE;
            rr         <= 1'b1;
            lock_cnt   <= 8'd0;
            lock_owner <= 2'b00;
          end else begin
            lock_cnt <= cnt_inc;
          end
        end
        LOCK_B: begin
          if (!req_b || !lock_b || cnt_inc == 8'(MAX_LOCK)) begin
            state      <= IDLE;
            rr         <= 1'b0;
            lock_cnt   <= 8'd0;
            lock_owner <= 2'b00;
          end else begin
            lock_cnt <= cnt_inc;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
